// File: rtl/puf_pkg.sv
// Shared types and defaults for the RO PUF response path.
// State encoding, default widths and counter-width helper.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int RESP_W_DEF  = 32;
  localparam int CHAL_W_DEF  = 8;
  localparam int TMO_CYC_DEF = 4096;
  localparam int VOTES_DEF   = 5;

  // Width of a counter that must hold values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TMR_W_DEF = cnt_w(TMO_CYC_DEF);

endpackage

// File: rtl/puf_vote_acc.sv
// Vote counter and ones counter for repeated measurements of one challenge.
// o_last marks the final vote; o_bit is the majority including the current bit.
module puf_vote_acc
  import puf_pkg::*;
#(
  parameter int VOTES = VOTES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_done,
  input  logic i_bit,
  output logic o_last,
  output logic o_bit
);

  localparam int VW = cnt_w(VOTES + 1);

  logic [VW-1:0] r_vote;
  logic [VW-1:0] r_ones;
  logic [VW-1:0] w_ones_sum;

  assign w_ones_sum = r_ones + VW'(i_bit);
  assign o_last     = (r_vote == VW'(VOTES - 1));
  assign o_bit      = (w_ones_sum > VW'(VOTES / 2));

  // Count votes and ones; restart after the last vote of a challenge.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_vote <= '0;
      r_ones <= '0;
    end else if (i_done) begin
      if (o_last) begin
        r_vote <= '0;
        r_ones <= '0;
      end else begin
        r_vote <= r_vote + 1'b1;
        r_ones <= w_ones_sum;
      end
    end
  end

endmodule

// File: rtl/puf_response_assembler.sv
// Steps challenges, collects comparator bits and hands out the packed key.
// Optional PUF_MAJORITY_VOTE_EN: each bit is a majority over VOTES requests.
module puf_response_assembler
  import puf_pkg::*;
#(
  parameter int RESP_W      = RESP_W_DEF,
  parameter int CHAL_W      = CHAL_W_DEF,
  parameter int TIMEOUT_CYC = TMO_CYC_DEF,
  parameter int VOTES       = VOTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              meas_req,
  output logic [CHAL_W-1:0] meas_chal,
  input  logic              meas_done,
  input  logic              meas_bit,
  output logic [RESP_W-1:0] key_out,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              err
);

  localparam int TMR_W = cnt_w(TIMEOUT_CYC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CHAL_W-1:0] r_idx;
  logic [CHAL_W-1:0] r_chal;
  logic [TMR_W-1:0]  r_timer;
  logic [RESP_W-1:0] r_key;
  logic              r_meas_req;
  logic              r_err;

  logic w_start;
  logic w_done;
  logic w_tmo;
  logic w_last_idx;
  logic w_vote_last;
  logic w_vote_bit;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_done     = (r_state == ST_WAIT) && meas_done;
  assign w_tmo      = (r_state == ST_WAIT) && !meas_done &&
                      (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  assign w_last_idx = (r_idx == CHAL_W'(RESP_W - 1));

`ifdef PUF_MAJORITY_VOTE_EN
  puf_vote_acc #(
    .VOTES (VOTES)
  ) u_vote (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_done (w_done),
    .i_bit  (meas_bit),
    .o_last (w_vote_last),
    .o_bit  (w_vote_bit)
  );
`else
  logic w_unused_votes;
  assign w_vote_last    = 1'b1;
  assign w_vote_bit     = meas_bit;
  assign w_unused_votes = (VOTES != 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: a done in WAIT beats a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (meas_done) begin
          if (w_vote_last && w_last_idx) w_state_nxt = ST_OUT;
          else                           w_state_nxt = ST_REQ;
        end else if (w_tmo) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OUT:  if (key_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: request pulse, challenge index, timer, key packing, error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meas_req <= 1'b0;
      r_chal     <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_key      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_meas_req <= 1'b0;
      if (w_start) begin
        r_key <= '0;
        r_idx <= '0;
        r_err <= 1'b0;
      end
      if (r_state == ST_REQ) begin
        r_meas_req <= 1'b1;
        r_chal     <= r_idx;
        r_timer    <= '0;
      end
      if (r_state == ST_WAIT) r_timer <= r_timer + 1'b1;
      if (w_done && w_vote_last) begin
        for (int i = 0; i < RESP_W; i++) begin
          if (r_idx == CHAL_W'(i)) r_key[i] <= w_vote_bit;
        end
        if (!w_last_idx) r_idx <= r_idx + 1'b1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
        r_key <= '0;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign key_valid = (r_state == ST_OUT);
  assign key_out   = key_valid ? r_key : '0;
  assign meas_req  = r_meas_req;
  assign meas_chal = r_chal;
  assign err       = r_err;

endmodule

// File: tb/tb_puf_response_assembler.sv
// Directed bench for puf_response_assembler.
// Responder answers each request after 3 cycles; optional silent challenge.
module tb_puf_response_assembler;

  localparam int RESP_W = 32;
  localparam int CHAL_W = 8;
  localparam int TMO    = 64;
  localparam int VOTES  = 5;
  localparam int LAT    = 3;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NV = VOTES;
`else
  localparam int NV = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              meas_req;
  logic [CHAL_W-1:0] meas_chal;
  logic              meas_done;
  logic              meas_bit;
  logic [RESP_W-1:0] key_out;
  logic              key_valid;
  logic              key_ready;
  logic              err;

  logic resp_done = 1'b0;
  logic resp_bit  = 1'b0;
  logic stray_done;
  logic stray_bit;

  assign meas_done = resp_done | stray_done;
  assign meas_bit  = stray_done ? stray_bit : resp_bit;

  puf_response_assembler #(
    .RESP_W      (RESP_W),
    .CHAL_W      (CHAL_W),
    .TIMEOUT_CYC (TMO),
    .VOTES       (VOTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .meas_req  (meas_req),
    .meas_chal (meas_chal),
    .meas_done (meas_done),
    .meas_bit  (meas_bit),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int silent_idx = -1;
  int resp_mode  = 0;
  int vote_base  = 0;

  int chal_log [0:2047];
  int req_cyc  [0:2047];
  int req_n     = 0;
  int last_chal = -1;
  int pend      = 0;
  logic pend_bit = 1'b0;
  logic [4:0] pat_a = 5'b01101;
  logic [4:0] pat_b = 5'b10100;

  // Measurement responder model.
  always @(negedge clk) begin
    int vn;
    resp_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        resp_done = 1'b1;
        resp_bit  = pend_bit;
      end
    end
    if (meas_req) begin
      if (req_n < 2048) begin
        chal_log[req_n] = int'(meas_chal);
        req_cyc[req_n]  = cyc;
      end
      last_chal = int'(meas_chal);
      if (int'(meas_chal) != silent_idx) begin
        pend = LAT;
        vn = (req_n - vote_base) % VOTES;
        if (resp_mode == 0) pend_bit = meas_chal[0];
        else if (meas_chal[0]) pend_bit = pat_b[vn];
        else pend_bit = pat_a[vn];
      end
      req_n = req_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int cs;
  task automatic pulse_start();
    start = 1'b1;
    cs    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_kv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic accept();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_req"},   64'(meas_req),  64'd0);
    check({tag, "_chal"},  64'(meas_chal), 64'd0);
    check({tag, "_key"},   64'(key_out),   64'd0);
    check({tag, "_valid"}, 64'(key_valid), 64'd0);
    check({tag, "_err"},   64'(err),       64'd0);
  endtask

  initial begin
    bit ok;
    int base;
    int vc;
    int n0;
    logic [RESP_W-1:0] k0;

    rst        = 1'b1;
    start      = 1'b0;
    key_ready  = 1'b0;
    stray_done = 1'b0;
    stray_bit  = 1'b0;
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // 1: full key generation, bit = idx[0].
    base = req_n;
    pulse_start();
    wait_kv(300 * NV, ok);
    vc = cyc;
    check("t1_valid_seen", 64'(ok), 64'd1);
    check("t1_req_count", 64'(req_n - base), 64'(32 * NV));
    for (int i = 0; i < 32; i++)
      check($sformatf("t1_chal%0d", i), 64'(chal_log[base + i * NV]), 64'(i));
    check("t1_first_req_lat", 64'(req_cyc[base] - cs), 64'd2);
    check("t1_req_gap", 64'(req_cyc[base + 1] - req_cyc[base]), 64'd5);
    check("t1_valid_lat", 64'(vc - req_cyc[base + 32 * NV - 1]), 64'd4);
    check("t1_key", 64'(key_out), 64'hAAAA_AAAA);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_err", 64'(err), 64'd0);

    // 2: backpressure holds the key stable.
    k0 = key_out;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_key_hold", 64'(key_out), 64'(k0));
      check("t2_valid_hold", 64'(key_valid), 64'd1);
    end
    accept();
    check("t2_valid_drop", 64'(key_valid), 64'd0);
    check("t2_busy_drop", 64'(busy), 64'd0);
    check("t2_key_zero", 64'(key_out), 64'd0);

    // 3: silent responder on idx 5 times out.
    silent_idx = 5;
    base = req_n;
    n0 = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200 * NV; i++) begin
      if (key_valid) n0++;
      if (err) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("t3_err_seen", 64'(ok), 64'd1);
    check("t3_err_lat", 64'(cyc - req_cyc[base + 5 * NV]), 64'(TMO));
    check("t3_no_valid", 64'(n0), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_key_zero", 64'(key_out), 64'd0);
    check("t3_req_count", 64'(req_n - base), 64'(5 * NV + 1));
    step();
    check("t3_err_sticky", 64'(err), 64'd1);
    silent_idx = -1;
    pulse_start();
    check("t3_err_clear", 64'(err), 64'd0);
    wait_kv(300 * NV, ok);
    check("t3_retry_valid", 64'(ok), 64'd1);
    check("t3_retry_key", 64'(key_out), 64'hAAAA_AAAA);
    accept();

    // 4: reset in WAIT of idx 12; the late done must be ignored.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200 * NV; i++) begin
      if (last_chal == 12) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("t4_idx12_seen", 64'(ok), 64'd1);
    rst = 1'b1;
    step();
    check_reset("t4_rst");
    rst = 1'b0;
    n0 = req_n;
    repeat (6) step();
    check("t4_no_req", 64'(req_n - n0), 64'd0);
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_no_valid", 64'(key_valid), 64'd0);

    // 5: stray done in IDLE and start while busy.
    stray_done = 1'b1;
    stray_bit  = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    check("t5_stray_busy", 64'(busy), 64'd0);
    check("t5_stray_valid", 64'(key_valid), 64'd0);
    base = req_n;
    pulse_start();
    repeat (20) step();
    pulse_start();
    wait_kv(300 * NV, ok);
    check("t5_valid_seen", 64'(ok), 64'd1);
    check("t5_req_count", 64'(req_n - base), 64'(32 * NV));
    check("t5_last_chal", 64'(chal_log[base + 32 * NV - 1]), 64'd31);
    check("t5_key", 64'(key_out), 64'hAAAA_AAAA);
    accept();
    check("t5_idle", 64'(busy), 64'd0);

`ifdef PUF_MAJORITY_VOTE_EN
    // 6: majority vote, even idx -> 1,0,1,1,0; odd idx -> 0,0,1,0,1.
    resp_mode = 1;
    base = req_n;
    vote_base = req_n;
    pulse_start();
    wait_kv(1200, ok);
    check("t6_valid_seen", 64'(ok), 64'd1);
    check("t6_req_count", 64'(req_n - base), 64'd160);
    check("t6_chal_v4", 64'(chal_log[base + 4]), 64'd0);
    check("t6_chal_v5", 64'(chal_log[base + 5]), 64'd1);
    check("t6_key", 64'(key_out), 64'h5555_5555);
    accept();
    resp_mode = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
